// File: rtl/lsu_mem_ctrl_if.sv
// Request, response and data-memory signals of the load/store unit.
// Latency: none; this is a bundle of wires.
// Backpressure: req_ready and resp_ready carry it; the memory side has no stall.
interface lsu_mem_ctrl_if #(
  parameter int n = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [2:0]   req_funct3;
  logic [n-1:0] req_addr;
  logic [n-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [n-1:0] resp_rdata;
  logic         resp_error;
  logic [n-1:0] mem_addr;
  logic         mem_write_enable;
  logic [n-1:0] mem_write_data;
  logic [n-1:0] mem_read_data;

  // Core/execute side together with the memory model.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_addr, mem_write_enable, mem_write_data
  );

  // The load/store controller itself.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: extends sub-word loads, read-modify-writes sub-word stores.
// Latency from accept edge T: error T+1, load/SW T+2, SB/SH T+3 to resp_valid.
// Backpressure: req_ready only in IDLE; response held until resp_ready.
module lsu_mem_ctrl #(
  parameter int n      = 32,
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         reset,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STORE  = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]   state_q,  state_d;
  logic [n-1:0] addr_q,   addr_d;
  logic [n-1:0] wdata_q,  wdata_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [n-1:0] merge_q,  merge_d;
  logic [n-1:0] rdata_q,  rdata_d;
  logic         error_q,  error_d;

  logic         req_err;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;
  logic [n-1:0] load_ext;
  logic [4:0]   shamt;
  logic [n-1:0] lane_mask;
  logic [n-1:0] lane_data;
  logic [n-1:0] merged;

  // Misalignment / illegal-funct3 check on the incoming request.
  always_comb begin
    logic misaligned;
    logic illegal;
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
    if (bus.req_write)
      illegal = (bus.req_funct3 > 3'b010);
    else
      illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    req_err = misaligned || illegal;
  end

  // Lane extraction and sign/zero extension of the loaded word.
  always_comb begin
    lane_b = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    lane_h = bus.mem_read_data[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{(n-8){lane_b[7] & ~funct3_q[2]}}, lane_b};
      2'b01:   load_ext = {{(n-16){lane_h[15] & ~funct3_q[2]}}, lane_h};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  // Merge of the store lane into the word captured during RMW_RD.
  always_comb begin
    shamt = {addr_q[1:0], 3'b000};
    if (funct3_q[0]) begin
      lane_mask = {{(n-16){1'b0}}, 16'hFFFF} << shamt;
      lane_data = {{(n-16){1'b0}}, wdata_q[15:0]} << shamt;
    end else begin
      lane_mask = {{(n-8){1'b0}}, 8'hFF} << shamt;
      lane_data = {{(n-8){1'b0}}, wdata_q[7:0]} << shamt;
    end
    merged = (merge_q & ~lane_mask) | lane_data;
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          rdata_d  = '0;
          error_d  = req_err;
          if (req_err)                     state_d = S_RESP;
          else if (!bus.req_write)         state_d = S_LOAD;
          else if (bus.req_funct3 == 3'b010) state_d = S_STORE;
          else                             state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_STORE:  state_d = S_RESP;
      S_RMW_RD: begin
        merge_d = bus.mem_read_data;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight access and pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // The memory decodes only the low ADDR_W index bits; the rest pass through.
  assign bus.mem_addr         = {2'b00, addr_q[n-1:ADDR_W+2], addr_q[ADDR_W+1:2]};
  assign bus.mem_write_enable = (state_q == S_STORE) || (state_q == S_RMW_WR);
  assign bus.mem_write_data   = (state_q == S_STORE)  ? wdata_q :
                                (state_q == S_RMW_WR) ? merged  : '0;
  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.resp_valid       = (state_q == S_RESP);
  assign bus.resp_rdata       = rdata_q;
  assign bus.resp_error       = error_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl against a 1K-word memory model.
// Latency: checks response cycle and write-strobe cycle relative to accept.
// Backpressure: holds resp_ready low with a competing request pending.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.n(32)) bus ();
  lsu_mem_ctrl #(.n(32), .ADDR_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem [0:1023];
  logic        pre_en;
  logic [31:0] pre_dat;
  assign bus.mem_read_data = mem[bus.mem_addr[9:0]];

  // Memory model: preload port for word 0x10, otherwise DUT writes.
  always @(posedge clk) begin
    if (pre_en) mem[16] <= pre_dat;
    else if (bus.mem_write_enable) mem[bus.mem_addr[9:0]] <= bus.mem_write_data;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic preload(input logic [31:0] d);
    @(negedge clk);
    pre_dat = d;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output int wcnt,
                         output int wk, output logic [31:0] rdata, output logic err);
    lat = 0; wcnt = 0; wk = 0; rdata = '0; err = 1'b0;
    @(negedge clk);
    drive(wr, f3, a, wd);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.mem_write_enable) begin wcnt++; wk = k; end
      if (bus.resp_valid) begin
        lat = k; rdata = bus.resp_rdata; err = bus.resp_error;
        break;
      end
    end
    if (lat != 0) begin
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wcnt, wk, got_resp;
    logic [31:0] rd;
    logic        er;
    logic [2:0]  ld_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ld_a   [4] = '{32'h41, 32'h41, 32'h42, 32'h42};
    logic [31:0] ld_exp [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
    logic        er_w   [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  er_f3  [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] er_a   [3] = '{32'h42, 32'h41, 32'h40};

    reset = 1'b1; pre_en = 1'b0; pre_dat = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mem_we", bus.mem_write_enable, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_error", bus.resp_error, 0);
    reset = 1'b0;

    preload(32'h8899AABB);
    run_req(1'b0, 3'b010, 32'h40, 32'h0, lat, wcnt, wk, rd, er);
    chk("lw_latency", lat, 2);
    chk("lw_rdata", rd, 32'h8899AABB);
    chk("lw_error", er, 0);
    chk("lw_no_write", wcnt, 0);

    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, ld_f3[i], ld_a[i], 32'h0, lat, wcnt, wk, rd, er);
      chk($sformatf("load%0d_rdata", i), rd, ld_exp[i]);
      chk($sformatf("load%0d_latency", i), lat, 2);
    end

    run_req(1'b1, 3'b000, 32'h43, 32'h12345677, lat, wcnt, wk, rd, er);
    chk("sb_latency", lat, 3);
    chk("sb_strobe_count", wcnt, 1);
    chk("sb_strobe_cycle", wk, 2);
    chk("sb_rdata", rd, 0);
    chk("sb_mem", mem[16], 32'h7799AABB);

    run_req(1'b1, 3'b001, 32'h40, 32'h0000CDEF, lat, wcnt, wk, rd, er);
    chk("sh_latency", lat, 3);
    chk("sh_strobe_cycle", wk, 2);
    chk("sh_mem", mem[16], 32'h7799CDEF);

    run_req(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, lat, wcnt, wk, rd, er);
    chk("sw_latency", lat, 2);
    chk("sw_strobe_count", wcnt, 1);
    chk("sw_strobe_cycle", wk, 1);
    chk("sw_mem", mem[16], 32'hDEADBEEF);

    for (int i = 0; i < 3; i++) begin
      run_req(er_w[i], er_f3[i], er_a[i], 32'h11111111, lat, wcnt, wk, rd, er);
      chk($sformatf("err%0d_latency", i), lat, 1);
      chk($sformatf("err%0d_flag", i), er, 1);
      chk($sformatf("err%0d_rdata", i), rd, 0);
      chk($sformatf("err%0d_no_write", i), wcnt, 0);
    end
    chk("err_mem_unchanged", mem[16], 32'hDEADBEEF);

    // Response backpressure with a competing request held on the bus.
    preload(32'h8899AABB);
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h40, 32'h0);
    @(posedge clk);
    #1 drive(1'b0, 3'b000, 32'h41, 32'h0);
    repeat (2) @(negedge clk);
    chk("bp_resp_valid", bus.resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), bus.resp_valid, 1);
      chk($sformatf("bp_hold%0d_rdata", i), bus.resp_rdata, 32'h8899AABB);
      chk($sformatf("bp_hold%0d_req_ready", i), bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_req_ready", bus.req_ready, 1);
    chk("bp_idle_resp_valid", bus.resp_valid, 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", bus.req_ready, 0);
    got_resp = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.resp_valid) begin got_resp = 1; break; end
      @(negedge clk);
    end
    chk("bp_second_resp", got_resp, 1);
    chk("bp_second_rdata", bus.resp_rdata, 32'hFFFFFFAA);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;

    // Reset while the sub-word store is in its read phase.
    preload(32'h8899AABB);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h40, 32'h00000055);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_ready_low", bus.req_ready, 0);
    reset = 1'b1;
    #1;
    chk("arst_req_ready", bus.req_ready, 1);
    chk("arst_mem_we", bus.mem_write_enable, 0);
    chk("arst_resp_valid", bus.resp_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_mem_unchanged", mem[16], 32'h8899AABB);
    chk("arst_idle_ready", bus.req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
